// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: states, opcodes,
// ALU operations, immediate/write-back selects and the control bundle.
package rv_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_rw;
        logic       ir_write;
        logic       pc_write;
        logic       w_en;
        logic [2:0] imm_sel;
        logic       a_sel;
        logic       b_sel;
        logic       br_un;
        logic       pc_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic logic opcode_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // funct3[0] inverts the base condition; funct3[2] picks less-than over equal.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Fetch/data-memory handshake between the control FSM (master) and memory (slave).
// instrValid and memReady are single-cycle completions; MemReq stays high until one is seen.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        instrValid;
    logic        memReady;
    logic        MemReq;
    logic        MemRW;

    modport master (input instr, input instrValid, input memReady, output MemReq, output MemRW);
    modport slave  (output instr, output instrValid, output memReady, input MemReq, input MemRW);
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU operation decode from the latched opcode/funct3/funct7.
module alu_op_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op
);

    logic funct7_unused;
    assign funct7_unused = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_R || opcode == OP_I) begin
            case (funct3)
                3'b000:  alu_op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control unit: FETCH/DECODE/EXEC/MEM/WB with a per-request
// wait timeout and a sticky FAULT state left only through rst.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_control_if.master   bus,
    input  logic                   BrEq,
    input  logic                   BrLT,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   wEn,
    output logic [ALUOP_W-1:0]     ALUOp,
    output logic [2:0]             ImmSel,
    output logic                   ASel,
    output logic                   BSel,
    output logic                   BrUn,
    output logic                   PCSel,
    output logic [1:0]             WBSel,
    output logic                   fault,
    output logic [2:0]             state
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [2:0]       state_q, next_state;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             at_limit;
    logic             alu_en;
    logic [3:0]       alu_op;
    ctrl_t            c, c_out;
    logic             instr_unused;

    assign instr_unused = ^{bus.instr[24:15], bus.instr[11:7]};
    assign at_limit     = (wait_cnt == CNT_W'(MEM_TIMEOUT));

    alu_op_decode u_alu_op_decode (
        .opcode (opcode_q),
        .funct3 (funct3_q),
        .funct7 (funct7_q),
        .alu_op (alu_op)
    );

    always_comb begin
        c          = '0;
        alu_en     = 1'b0;
        next_state = state_q;
        case (state_q)
            ST_FETCH: begin
                c.mem_req = 1'b1;
                if (bus.instrValid) begin
                    c.ir_write = 1'b1;
                    next_state = ST_DECODE;
                end else if (at_limit) begin
                    next_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
                // BRANCH funct3 010/011 have no defined comparison.
                if (!opcode_supported(opcode_q) ||
                    (opcode_q == OP_BRANCH && funct3_q[2:1] == 2'b01))
                    next_state = ST_FAULT;
                else
                    next_state = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en = 1'b1;
                case (opcode_q)
                    OP_R: next_state = ST_WB;
                    OP_I: begin
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_I;
                        next_state = ST_WB;
                    end
                    OP_LUI: begin
                        // A stays on rs1 (x0 for LUI), so ADD yields the U immediate.
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_U;
                        next_state = ST_WB;
                    end
                    OP_LOAD: begin
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_I;
                        next_state = ST_MEM;
                    end
                    OP_STORE: begin
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_S;
                        next_state = ST_MEM;
                    end
                    OP_BRANCH: begin
                        c.a_sel    = 1'b1;
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_B;
                        c.br_un    = funct3_q[1];
                        c.pc_sel   = branch_taken(funct3_q, BrEq, BrLT);
                        c.pc_write = 1'b1;
                        next_state = ST_FETCH;
                    end
                    OP_JAL: begin
                        c.a_sel    = 1'b1;
                        c.b_sel    = 1'b1;
                        c.imm_sel  = IMM_J;
                        next_state = ST_WB;
                    end
                    default: next_state = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.mem_rw  = (opcode_q == OP_STORE);
                if (bus.memReady) begin
                    if (opcode_q == OP_STORE) begin
                        c.pc_write = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (at_limit) begin
                    next_state = ST_FAULT;
                end
            end
            ST_WB: begin
                c.w_en     = 1'b1;
                c.pc_write = 1'b1;
                c.pc_sel   = (opcode_q == OP_JAL);
                if (opcode_q == OP_LOAD)     c.wb_sel = WB_MEM;
                else if (opcode_q == OP_JAL) c.wb_sel = WB_PC4;
                else                         c.wb_sel = WB_ALU;
                next_state = ST_FETCH;
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            wait_cnt <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
        end else begin
            state_q <= next_state;
            if (next_state != state_q)
                wait_cnt <= '0;
            else if (state_q == ST_FETCH || state_q == ST_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            if (state_q == ST_FETCH && bus.instrValid) begin
                opcode_q <= bus.instr[6:0];
                funct3_q <= bus.instr[14:12];
                funct7_q <= bus.instr[31:25];
            end
        end
    end

    // Every output is forced low while rst is held, so an abort never writes.
    assign c_out      = rst ? '0 : c;
    assign bus.MemReq = c_out.mem_req;
    assign bus.MemRW  = c_out.mem_rw;
    assign IRWrite    = c_out.ir_write;
    assign PCWrite    = c_out.pc_write;
    assign wEn        = c_out.w_en;
    assign ImmSel     = c_out.imm_sel;
    assign ASel       = c_out.a_sel;
    assign BSel       = c_out.b_sel;
    assign BrUn       = c_out.br_un;
    assign PCSel      = c_out.pc_sel;
    assign WBSel      = c_out.wb_sel;
    assign ALUOp      = (rst || !alu_en) ? '0 : ALUOP_W'(alu_op);
    assign fault      = !rst && (state_q == ST_FAULT);
    assign state      = rst ? ST_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction model builds the cycle-by-cycle
// stimulus and expected outputs, and each scenario task replays and compares them.
module tb_multicycle_control;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic BrEq = 1'b0, BrLT = 1'b0;
    logic IRWrite, PCWrite, wEn, ASel, BSel, BrUn, PCSel, fault;
    logic [3:0] ALUOp;
    logic [2:0] ImmSel, state;
    logic [1:0] WBSel;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .BrEq(BrEq), .BrLT(BrLT),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .wEn(wEn), .ALUOp(ALUOp),
        .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn), .PCSel(PCSel),
        .WBSel(WBSel), .fault(fault), .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       flt;
        logic       mreq, mrw, irw, pcw, wen;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       a, b, un, pcs;
        logic [1:0] wb;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        ready;
        logic        breq;
        logic        brlt;
        logic [31:0] instr;
    } stim_t;

    localparam int OBS_W = $bits(obs_t);

    logic [OBS_W-1:0] exp_q[$];
    stim_t            stim_q[$];
    int               checks = 0;
    int               failures = 0;

    // ---------------- clock/reset + driver ----------------
    task automatic drive_cycle(input stim_t s, output obs_t o);
        @(posedge clk);
        #1;
        rst            = s.rst;
        bus.instrValid = s.valid;
        bus.memReady   = s.ready;
        BrEq           = s.breq;
        BrLT           = s.brlt;
        bus.instr      = s.instr;
        @(negedge clk);
        o = {state, fault, bus.MemReq, bus.MemRW, IRWrite, PCWrite, wEn,
             ALUOp, ImmSel, ASel, BSel, BrUn, PCSel, WBSel};
    endtask

    // ---------------- reference model ----------------
    function automatic stim_t rnd_stim(input logic valid, input logic ready);
        stim_t s;
        s.rst   = 1'b0;
        s.valid = valid;
        s.ready = ready;
        s.breq  = 1'($urandom_range(0, 1));
        s.brlt  = 1'($urandom_range(0, 1));
        s.instr = $urandom();
        return s;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t in_state(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    task automatic push(input stim_t s, input obs_t o);
        stim_q.push_back(s);
        exp_q.push_back(o);
    endtask

    task automatic gen_fault(input int n);
        obs_t o;
        o = in_state(3'd5);
        o.flt = 1'b1;
        for (int i = 0; i < n; i++) push(rnd_stim(rbit(), rbit()), o);
    endtask

    task automatic gen_reset(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd_stim(rbit(), rbit());
            s.rst = 1'b1;
            push(s, '0);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5);
        logic [3:0] tbl [8];
        logic [3:0] r;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (opc != 7'b0110011 && opc != 7'b0010011) return 4'd0;
        r = tbl[f3];
        if (f3 == 3'd0 && opc == 7'b0110011 && f7b5) r = 4'd1;
        if (f3 == 3'd5 && f7b5) r = 4'd7;
        return r;
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            default:    return !lt;
        endcase
    endfunction

    // One instruction: fwait idle fetch cycles, mwait memory wait cycles,
    // breq/brlt held during EXEC. Waits beyond TIMEOUT lead into FAULT.
    task automatic gen_instr(input logic [31:0] ins, input int fwait, input int mwait,
                             input logic breq, input logic brlt);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       is_ld, is_st, is_br, is_jal, bad;
        obs_t       o;
        stim_t      s;
        int         n;
        opc    = ins[6:0];
        f3     = ins[14:12];
        is_ld  = (opc == 7'b0000011);
        is_st  = (opc == 7'b0100011);
        is_br  = (opc == 7'b1100011);
        is_jal = (opc == 7'b1101111);
        bad    = !(opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b1101111, 7'b0110111}) ||
                 (is_br && (f3 == 3'd2 || f3 == 3'd3));
        n = (fwait > TIMEOUT) ? TIMEOUT + 1 : fwait;
        for (int i = 0; i < n; i++) begin
            o = in_state(3'd0);
            o.mreq = 1'b1;
            push(rnd_stim(1'b0, 1'b0), o);
        end
        if (fwait > TIMEOUT) begin
            gen_fault(4);
            return;
        end
        o = in_state(3'd0);
        o.mreq = 1'b1;
        o.irw  = 1'b1;
        s = rnd_stim(1'b1, 1'b0);
        s.instr = ins;
        push(s, o);
        push(rnd_stim(rbit(), rbit()), in_state(3'd1));
        if (bad) begin
            gen_fault(5);
            return;
        end
        o = in_state(3'd2);
        o.alu = ref_alu(opc, f3, ins[30]);
        case (opc)
            7'b0010011: begin o.b = 1'b1; o.imm = 3'd0; end
            7'b0110111: begin o.b = 1'b1; o.imm = 3'd3; end
            7'b0000011: begin o.b = 1'b1; o.imm = 3'd0; end
            7'b0100011: begin o.b = 1'b1; o.imm = 3'd1; end
            7'b1100011: begin
                o.a = 1'b1; o.b = 1'b1; o.imm = 3'd2; o.un = f3[1];
                o.pcs = ref_taken(f3, breq, brlt); o.pcw = 1'b1;
            end
            7'b1101111: begin o.a = 1'b1; o.b = 1'b1; o.imm = 3'd4; end
            default: ;
        endcase
        s = rnd_stim(rbit(), rbit());
        s.breq = breq;
        s.brlt = brlt;
        push(s, o);
        if (is_br) return;
        if (is_ld || is_st) begin
            n = (mwait > TIMEOUT) ? TIMEOUT + 1 : mwait;
            for (int j = 0; j < n; j++) begin
                o = in_state(3'd3);
                o.mreq = 1'b1;
                o.mrw  = is_st;
                push(rnd_stim(rbit(), 1'b0), o);
            end
            if (mwait > TIMEOUT) begin
                gen_fault(4);
                return;
            end
            o = in_state(3'd3);
            o.mreq = 1'b1;
            o.mrw  = is_st;
            o.pcw  = is_st;
            push(rnd_stim(rbit(), 1'b1), o);
            if (is_st) return;
        end
        o = in_state(3'd4);
        o.wen = 1'b1;
        o.pcw = 1'b1;
        o.pcs = is_jal;
        o.wb  = is_ld ? 2'd0 : (is_jal ? 2'd2 : 2'd1);
        push(rnd_stim(rbit(), rbit()), o);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 6))
            0:       w[6:0] = 7'b0110011;
            1:       w[6:0] = 7'b0010011;
            2:       w[6:0] = 7'b0000011;
            3:       w[6:0] = 7'b0100011;
            4:       w[6:0] = 7'b1100011;
            5:       w[6:0] = 7'b1101111;
            default: w[6:0] = 7'b0110111;
        endcase
        if (w[6:0] == 7'b1100011)
            while (w[14:13] == 2'b01) w[14:12] = 3'($urandom_range(0, 7));
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o, e;
        int cyc = 0;
        gen_reset(2);
        gen_instr(32'h002081B3, 3, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_directed();
        obs_t o, e;
        int cyc = 0;
        gen_instr(32'h002081B3, 0, 0, 1'b0, 1'b0); // add
        gen_instr(32'h402081B3, 0, 0, 1'b0, 1'b0); // sub
        gen_instr(32'h4020D093, 0, 0, 1'b0, 1'b0); // srai
        gen_instr(32'h00209463, 0, 0, 1'b0, 1'b0); // bne, not equal
        gen_instr(32'h0020F463, 0, 0, 1'b0, 1'b1); // bgeu, less
        gen_instr(32'h00012083, 0, 3, 1'b0, 1'b0); // lw, ready after 3
        gen_instr(32'h00112023, 1, 2, 1'b0, 1'b0); // sw
        gen_instr(32'h008000EF, 0, 0, 1'b0, 1'b0); // jal
        gen_instr(32'h000120B7, 0, 0, 1'b0, 1'b0); // lui
        gen_instr(32'h00012083, TIMEOUT, TIMEOUT, 1'b0, 1'b0); // waits at the limit
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL directed cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int cyc = 0;
        for (int i = 0; i < 60; i++)
            gen_instr(rnd_instr(),
                      ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 5),
                      rbit(), rbit());
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int cyc = 0;
        for (int i = 0; i < 30; i++) gen_instr(rnd_instr(), 0, 0, rbit(), rbit());
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_timeouts();
        obs_t o, e;
        int cyc = 0;
        gen_instr(32'h00012083, 0, 1000, 1'b0, 1'b0); // memReady never comes
        gen_fault(6);
        gen_reset(1);
        gen_instr(32'h002081B3, TIMEOUT + 1, 0, 1'b0, 1'b0); // instrValid never comes
        gen_reset(1);
        gen_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_bad_opcode();
        obs_t o, e;
        int cyc = 0;
        gen_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
        gen_reset(1);
        gen_instr(32'h0020A463, 0, 0, 1'b0, 1'b0); // branch funct3 010
        gen_reset(1);
        gen_instr(32'h00000033 | (32'd3 << 12), 0, 0, 1'b0, 1'b0); // sltu
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bad_opcode cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        int cyc = 0;
        gen_instr(32'h00012083, 0, 10, 1'b0, 1'b0); // keep FETCH, DECODE, EXEC, 2x MEM
        while (exp_q.size() > 5) begin
            void'(exp_q.pop_back());
            void'(stim_q.pop_back());
        end
        gen_reset(1);
        gen_instr(32'h002081B3, 0, 0, 1'b0, 1'b0); // cut before WB
        while (exp_q.size() > 9) begin
            void'(exp_q.pop_back());
            void'(stim_q.pop_back());
        end
        gen_reset(1);
        gen_instr(32'h008000EF, 0, 0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    initial begin
        bus.instr      = '0;
        bus.instrValid = 1'b0;
        bus.memReady   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeouts();
        test_bad_opcode();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4: width of ALUOp.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles per memory request.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port instr, input, 32: instruction word from fetch memory.
REQ-007 SHALL have port instrValid, input, 1: instr valid this cycle.
REQ-008 SHALL have port memReady, input, 1: data memory access complete this cycle.
REQ-009 SHALL have port BrEq / BrLT, input, 1 each: branch comparator results.
REQ-010 SHALL have port MemReq, output, 1: memory request; MemRW, output, 1: 1 = write.
REQ-011 SHALL have port IRWrite / PCWrite / wEn, output, 1 each: IR load, PC load, register-file write.
REQ-012 SHALL have port ALUOp, output, ALUOP_W: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9.
REQ-013 SHALL have port ImmSel, output, 3: I0 S1 B2 U3 J4.
REQ-014 SHALL have port ASel / BSel / BrUn / PCSel, output, 1 each: A=PC, B=imm, unsigned compare, PC=ALU result.
REQ-015 SHALL have port WBSel, output, 2: 0 mem, 1 ALU, 2 PC+4.
REQ-016 SHALL have port fault, output, 1: sticky error; state, output, 3: current FSM state.

Function
REQ-017 SHALL implement states FETCH0, DECODE1, EXEC2, MEM3, WB4, FAULT5; other encodings go to FAULT.
REQ-018 FETCH: MemReq=1, MemRW=0; on instrValid assert IRWrite, latch opcode/funct3/funct7, go to DECODE.
REQ-019 DECODE: supported opcodes are R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111; any other opcode, or branch funct3 010/011, goes to FAULT, otherwise EXEC.
REQ-020 ALUOp decode by funct3: 000 ADD (SUB if R and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND; LOAD/STORE/BRANCH/JAL/LUI use ADD.
REQ-021 EXEC R/I/LUI: BSel=!R, ASel=0, go to WB with WBSel=1; LUI forces A operand zero via ALU ADD of x0.
REQ-022 EXEC BRANCH: ASel=1, BSel=1, ImmSel=2, BrUn=funct3[1]; PCSel = BEQ:BrEq, BNE:!BrEq, BLT/BLTU:BrLT, BGE/BGEU:!BrLT, sampled same cycle; PCWrite=1; go to FETCH.
REQ-023 EXEC LOAD/STORE: ALUOp ADD, BSel=1, ImmSel 0/1; go to MEM.
REQ-024 EXEC JAL: ASel=1, BSel=1, ImmSel=4; go to WB with WBSel=2, PCSel=1.
REQ-025 MEM: MemReq=1, MemRW=1 for STORE; on memReady STORE asserts PCWrite (PCSel=0) and goes to FETCH, LOAD goes to WB with WBSel=0.
REQ-026 WB: wEn=1 and PCWrite=1 for exactly one cycle, then go to FETCH; PCSel=1 only for JAL.
REQ-027 Latency with zero memory wait: branch 3 cycles, R/I/LUI/JAL/STORE 4, LOAD 5.
REQ-028 A wait counter SHALL count cycles in FETCH/MEM without ready; it clears on every state change.
REQ-029 Counter equal to MEM_TIMEOUT with ready still low SHALL go to FAULT; ready in that cycle wins.
REQ-030 FAULT: fault=1, all other outputs 0, remains until rst.
REQ-031 Outputs not listed for a state SHALL be 0; wEn, PCWrite, IRWrite, MemReq SHALL never assert outside their stated states.

Reset
REQ-032 rst SHALL force state FETCH, counter 0, latched fields 0, fault 0, in the cycle after it is sampled high.
REQ-033 While rst is high, all outputs SHALL be 0; rst mid-instruction SHALL abort with no wEn/PCWrite.

Structure
REQ-034 State encodings, opcode constants, ALUOp and ImmSel/WBSel encodings SHALL live in a shared package rv_ctrl_pkg.
REQ-035 ALU decode (REQ-020) SHALL be one combinational sub-module alu_op_decode.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3), instrValid immediate -> state 0,1,2,4,0; wEn=1 in cycle 4 only, ALUOp=0.
REQ-037 SUB funct7=0x20 -> ALUOp=1; SRAI (0x4020D093) -> ALUOp=7, BSel=1.
REQ-038 BNE with BrEq=0 -> PCSel=1, PCWrite=1 in EXEC; BGEU with BrLT=1 -> PCSel=0, BrUn=1.
REQ-039 LOAD, memReady after 3 cycles -> MEM held 4 cycles, then WB with WBSel=0, wEn=1.
REQ-040 memReady never asserted, MEM_TIMEOUT=15 -> FAULT after 16 MEM cycles, fault sticky until rst.
REQ-041 opcode 0x7F -> FAULT from DECODE; rst asserted in MEM -> next state FETCH, no wEn.
